// File: rtl/ins_exec_rv_muldiv_pkg.sv
// ----------------------------------------------------------------------------
// ins_exec_rv_muldiv_pkg
// Shared constants and helpers for the RV M-extension execution unit:
// opcode / funct7 match values, the eight funct3 encodings, the FSM state
// enumeration and small decode helpers used by the top and the bench-visible
// datapath.
// ----------------------------------------------------------------------------
package ins_exec_rv_muldiv_pkg;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // All divide/remainder encodings have funct3[2] set.
    function automatic logic is_div_op(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic rs1_is_signed(input logic [2:0] f3);
        return (f3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM});
    endfunction

    function automatic logic rs2_is_signed(input logic [2:0] f3);
        return (f3 inside {F3_MULH, F3_DIV, F3_REM});
    endfunction

    function automatic logic is_rem_op(input logic [2:0] f3);
        return (f3 inside {F3_REM, F3_REMU});
    endfunction

    // Result comes from the upper half of the {hi, lo} datapath pair.
    function automatic logic takes_high_half(input logic [2:0] f3);
        return (f3 inside {F3_MULH, F3_MULHSU, F3_MULHU, F3_REM, F3_REMU});
    endfunction

endpackage

// File: rtl/ins_exec_rv_muldiv_fixup.sv
// ----------------------------------------------------------------------------
// ins_exec_rv_muldiv_fixup
// Combinational sign handling around the unsigned iterative core.
//   rs1_val/rs2_val + *_signed  -> *_mag (magnitude) and *_neg (sign flag)
//   res_in + res_negate         -> res_out (two's complement negation, 2*XLEN)
// The most-negative value maps to itself as a magnitude, which is exactly
// 2^(XLEN-1) when read as unsigned.
// ----------------------------------------------------------------------------
module ins_exec_rv_muldiv_fixup #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]   rs1_val,
    input  logic [XLEN-1:0]   rs2_val,
    input  logic              rs1_signed,
    input  logic              rs2_signed,
    output logic [XLEN-1:0]   rs1_mag,
    output logic [XLEN-1:0]   rs2_mag,
    output logic              rs1_neg,
    output logic              rs2_neg,
    input  logic [2*XLEN-1:0] res_in,
    input  logic              res_negate,
    output logic [2*XLEN-1:0] res_out
);

    localparam int W2 = 2 * XLEN;

    assign rs1_neg = rs1_signed & rs1_val[XLEN-1];
    assign rs2_neg = rs2_signed & rs2_val[XLEN-1];

    assign rs1_mag = rs1_neg ? ((~rs1_val) + XLEN'(1)) : rs1_val;
    assign rs2_mag = rs2_neg ? ((~rs2_val) + XLEN'(1)) : rs2_val;

    assign res_out = res_negate ? ((~res_in) + W2'(1)) : res_in;

endmodule

// File: rtl/ins_exec_rv_muldiv.sv
// ----------------------------------------------------------------------------
// ins_exec_rv_muldiv
// Iterative RV M-extension unit: MUL/MULH/MULHSU/MULHU by shift-add and
// DIV/DIVU/REM/REMU by restoring division, one bit per cycle on magnitudes,
// with sign fix-up applied on the way out.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   op                   instruction-valid strobe from decode
//   ins_dec_op/funct3/funct7  decoded instruction fields
//   reg_rs1_val/rs2_val  operands (XLEN)
//   reg_rd               destination register index
//   flush                abort current operation, no write-back
//   busy                 unit occupied; new ops are dropped
//   reg_w_op             one-cycle write strobe (DONE state)
//   reg_w_reg_idx/val    write-back index and value, zero when not writing
//
// Datapath registers
//   hi_reg/lo_reg  multiply: running product high / multiplier shifting out
//                  divide:   partial remainder / dividend-in, quotient-out
//   opa_reg        multiplicand magnitude or divisor magnitude
// ----------------------------------------------------------------------------
module ins_exec_rv_muldiv
    import ins_exec_rv_muldiv_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            op,
    input  logic [6:0]      ins_dec_op,
    input  logic [2:0]      ins_dec_funct3,
    input  logic [6:0]      ins_dec_funct7,
    input  logic [XLEN-1:0] reg_rs1_val,
    input  logic [XLEN-1:0] reg_rs2_val,
    input  logic [4:0]      reg_rd,
    input  logic            flush,
    output logic            busy,
    output logic            reg_w_op,
    output logic [4:0]      reg_w_reg_idx,
    output logic [XLEN-1:0] reg_w_reg_val
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [XLEN-1:0]   hi_reg;
    logic [XLEN-1:0]   lo_reg;
    logic [XLEN-1:0]   opa_reg;
    logic [2:0]        funct3_reg;
    logic [4:0]        rd_reg;
    logic              neg_q_reg;   // negate product / quotient
    logic              neg_r_reg;   // negate remainder

    // ------------------------------------------------------------------
    // Operand sign conversion (from live inputs) and result negation
    // (from captured registers) share one fix-up block.
    // ------------------------------------------------------------------
    logic [XLEN-1:0]   rs1_mag, rs2_mag;
    logic              rs1_neg, rs2_neg;
    logic [2*XLEN-1:0] res_in, res_out;
    logic              res_negate;

    // A remainder is negated on its own, so the low half is zeroed to keep
    // the 2*XLEN negation from borrowing into it.
    assign res_in     = is_rem_op(funct3_reg) ? {hi_reg, {XLEN{1'b0}}} : {hi_reg, lo_reg};
    assign res_negate = is_rem_op(funct3_reg) ? neg_r_reg : neg_q_reg;

    ins_exec_rv_muldiv_fixup #(.XLEN(XLEN)) u_fixup (
        .rs1_val    (reg_rs1_val),
        .rs2_val    (reg_rs2_val),
        .rs1_signed (rs1_is_signed(ins_dec_funct3)),
        .rs2_signed (rs2_is_signed(ins_dec_funct3)),
        .rs1_mag    (rs1_mag),
        .rs2_mag    (rs2_mag),
        .rs1_neg    (rs1_neg),
        .rs2_neg    (rs2_neg),
        .res_in     (res_in),
        .res_negate (res_negate),
        .res_out    (res_out)
    );

    // ------------------------------------------------------------------
    // Accept decode and special-case detection
    // ------------------------------------------------------------------
    logic accept;
    logic div_zero;
    logic div_ovf;
    logic take_fast;

    assign busy     = (state_reg != ST_IDLE);
    assign accept   = op & ~busy & ~flush &
                      (ins_dec_op == OPCODE_OP) & (ins_dec_funct7 == FUNCT7_MULDIV);
    assign div_zero = (reg_rs2_val == '0);
    assign div_ovf  = rs1_is_signed(ins_dec_funct3) &
                      (reg_rs1_val == MOST_NEG) & (reg_rs2_val == '1);
    assign take_fast = FAST_SPECIAL & is_div_op(ins_dec_funct3) & (div_zero | div_ovf);

    // ------------------------------------------------------------------
    // The single shared adder/subtractor.
    // DIV: trial subtract of the divisor from the remainder shifted left by
    //      one with the next dividend bit. The bit shifted out of hi_reg is
    //      an implicit 2^XLEN, so if it is set the trial always succeeds.
    // MUL: add multiplicand into the running high half.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] add_a, add_b, add_sum;
    logic            add_cin, add_cout;
    logic [XLEN:0]   add_full;
    logic            div_ok;

    always_comb begin
        if (state_reg == ST_DIV) begin
            add_a   = {hi_reg[XLEN-2:0], lo_reg[XLEN-1]};
            add_b   = ~opa_reg;
            add_cin = 1'b1;
        end else begin
            add_a   = hi_reg;
            add_b   = opa_reg;
            add_cin = 1'b0;
        end
    end

    assign add_full = {1'b0, add_a} + {1'b0, add_b} + {{XLEN{1'b0}}, add_cin};
    assign add_sum  = add_full[XLEN-1:0];
    assign add_cout = add_full[XLEN];
    assign div_ok   = hi_reg[XLEN-1] | add_cout;

    logic last_iter;
    assign last_iter = (cnt_reg == CNT_W'(XLEN - 1));

    // ------------------------------------------------------------------
    // FSM and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            opa_reg    <= '0;
            funct3_reg <= '0;
            rd_reg     <= '0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
        end else if (flush) begin
            state_reg <= ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        funct3_reg <= ins_dec_funct3;
                        rd_reg     <= reg_rd;
                        cnt_reg    <= '0;
                        if (is_div_op(ins_dec_funct3)) begin
                            // Divide by zero keeps the quotient positive so it
                            // stays all-ones; the remainder then equals rs1.
                            neg_q_reg <= (rs1_neg ^ rs2_neg) & ~div_zero;
                            neg_r_reg <= rs1_neg;
                            opa_reg   <= rs2_mag;
                            if (take_fast) begin
                                // Preload the final quotient/remainder
                                // magnitudes; fix-up produces the result.
                                hi_reg    <= div_zero ? rs1_mag : '0;
                                lo_reg    <= div_zero ? '1 : rs1_mag;
                                state_reg <= ST_DONE;
                            end else begin
                                hi_reg    <= '0;
                                lo_reg    <= rs1_mag;
                                state_reg <= ST_DIV;
                            end
                        end else begin
                            neg_q_reg <= rs1_neg ^ rs2_neg;
                            neg_r_reg <= 1'b0;
                            opa_reg   <= rs1_mag;
                            hi_reg    <= '0;
                            lo_reg    <= rs2_mag;
                            state_reg <= ST_MUL;
                        end
                    end
                end
                ST_MUL: begin
                    // {carry, hi, lo} >> 1 after optional add
                    if (lo_reg[0]) begin
                        hi_reg <= {add_cout, add_sum[XLEN-1:1]};
                        lo_reg <= {add_sum[0], lo_reg[XLEN-1:1]};
                    end else begin
                        hi_reg <= {1'b0, hi_reg[XLEN-1:1]};
                        lo_reg <= {hi_reg[0], lo_reg[XLEN-1:1]};
                    end
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (last_iter) begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_DIV: begin
                    hi_reg  <= div_ok ? add_sum : add_a;
                    lo_reg  <= {lo_reg[XLEN-2:0], div_ok};
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (last_iter) begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write-back: only in DONE, and a flush in that same cycle cancels it.
    // ------------------------------------------------------------------
    logic            w_fire;
    logic [XLEN-1:0] result;

    assign result        = takes_high_half(funct3_reg) ? res_out[2*XLEN-1:XLEN]
                                                       : res_out[XLEN-1:0];
    assign w_fire        = (state_reg == ST_DONE) & ~flush;
    assign reg_w_op      = w_fire;
    assign reg_w_reg_idx = w_fire ? rd_reg : 5'd0;
    assign reg_w_reg_val = w_fire ? result : '0;

endmodule

// File: tb/tb_ins_exec_rv_muldiv.sv
// ----------------------------------------------------------------------------
// tb_ins_exec_rv_muldiv
// Two instances: XLEN=32 with fast special cases, XLEN=64 without.
// A cycle-level reference model (accept rules, latency, plain 128-bit
// arithmetic for results) predicts busy and write-back every cycle; a compare
// process checks both instances on every falling edge. Directed transactions
// add literal expectations for values and latencies.
// ----------------------------------------------------------------------------
module tb_ins_exec_rv_muldiv;

    localparam logic [6:0] OPC  = 7'b0110011;
    localparam logic [6:0] F7MD = 7'b0000001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  op_v = 2'b00;
    logic [6:0]  dec_op = 7'd0;
    logic [2:0]  dec_f3 = 3'd0;
    logic [6:0]  dec_f7 = 7'd0;
    logic [63:0] rs1 = 64'd0;
    logic [63:0] rs2 = 64'd0;
    logic [4:0]  rd = 5'd0;

    logic        busy32, wop32, busy64, wop64;
    logic [4:0]  widx32, widx64;
    logic [31:0] wval32;
    logic [63:0] wval64;

    always #5 clk = ~clk;

    ins_exec_rv_muldiv #(.XLEN(32), .FAST_SPECIAL(1'b1)) dut32 (
        .clk(clk), .rst_n(rst_n), .op(op_v[0]), .ins_dec_op(dec_op),
        .ins_dec_funct3(dec_f3), .ins_dec_funct7(dec_f7),
        .reg_rs1_val(rs1[31:0]), .reg_rs2_val(rs2[31:0]), .reg_rd(rd),
        .flush(flush), .busy(busy32), .reg_w_op(wop32),
        .reg_w_reg_idx(widx32), .reg_w_reg_val(wval32)
    );

    ins_exec_rv_muldiv #(.XLEN(64), .FAST_SPECIAL(1'b0)) dut64 (
        .clk(clk), .rst_n(rst_n), .op(op_v[1]), .ins_dec_op(dec_op),
        .ins_dec_funct3(dec_f3), .ins_dec_funct7(dec_f7),
        .reg_rs1_val(rs1), .reg_rs2_val(rs2), .reg_rd(rd),
        .flush(flush), .busy(busy64), .reg_w_op(wop64),
        .reg_w_reg_idx(widx64), .reg_w_reg_val(wval64)
    );

    logic        o_busy[2], o_wop[2];
    logic [4:0]  o_idx[2];
    logic [63:0] o_val[2];
    assign o_busy[0] = busy32;  assign o_busy[1] = busy64;
    assign o_wop[0]  = wop32;   assign o_wop[1]  = wop64;
    assign o_idx[0]  = widx32;  assign o_idx[1]  = widx64;
    assign o_val[0]  = {32'd0, wval32};
    assign o_val[1]  = wval64;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    longint cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    function automatic logic [63:0] xmask(input int xlen);
        return (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << xlen) - 64'd1);
    endfunction

    function automatic logic [63:0] ref_result(input int xlen, input logic [2:0] f3,
                                               input logic [63:0] a, input logic [63:0] b);
        logic [127:0] m, ua, ub, sa, sb, p;
        logic signed [127:0] q;
        m  = (128'd1 << xlen) - 128'd1;
        ua = {64'd0, a} & m;
        ub = {64'd0, b} & m;
        sa = ua[xlen-1] ? (ua | ~m) : ua;
        sb = ub[xlen-1] ? (ub | ~m) : ub;
        p  = 128'd0;
        case (f3)
            3'd0: p = ua * ub;
            3'd1: p = (sa * sb) >> xlen;
            3'd2: p = (sa * ub) >> xlen;
            3'd3: p = (ua * ub) >> xlen;
            3'd4: begin
                if (ub == 0) p = m;
                else begin q = $signed(sa) / $signed(sb); p = q; end
            end
            3'd5: p = (ub == 0) ? m : ua / ub;
            3'd6: begin
                if (ub == 0) p = ua;
                else begin q = $signed(sa) % $signed(sb); p = q; end
            end
            default: p = (ub == 0) ? ua : ua % ub;
        endcase
        return p[63:0] & xmask(xlen);
    endfunction

    // ---------------- cycle model ----------------
    // cyc = number of rising edges so far; an op accepted at edge E keeps the
    // unit busy for cycles E .. E+lat-1 and writes in the last of those.
    bit          m_act[2];
    longint      m_start[2], m_end[2];
    logic [63:0] m_val[2];
    logic [4:0]  m_idx[2];
    longint      last_wcyc[2];
    logic [63:0] last_wval[2];

    always @(posedge clk) begin
        int xl;
        longint c, lat;
        bit was_busy, spec;
        logic [63:0] a, b;
        cyc = cyc + 1;
        for (int d = 0; d < 2; d++) begin
            xl = (d == 0) ? 32 : 64;
            c = cyc - 1;
            was_busy = m_act[d] && (c >= m_start[d]) && (c <= m_end[d]);
            if (!rst_n || flush) begin
                m_act[d] = 1'b0;
            end else if (op_v[d] && !was_busy && dec_op == OPC && dec_f7 == F7MD) begin
                a = rs1 & xmask(xl);
                b = rs2 & xmask(xl);
                spec = dec_f3[2] && (b == 0 ||
                       ((dec_f3 == 3'd4 || dec_f3 == 3'd6) &&
                        a == (64'd1 << (xl - 1)) && b == xmask(xl)));
                lat = (spec && d == 0) ? 1 : xl + 1;
                m_act[d]   = 1'b1;
                m_start[d] = cyc;
                m_end[d]   = cyc + lat - 1;
                m_val[d]   = ref_result(xl, dec_f3, a, b);
                m_idx[d]   = rd;
            end else if (m_act[d] && c >= m_end[d]) begin
                m_act[d] = 1'b0;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        bit eb, ew;
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                eb = m_act[d] && cyc >= m_start[d] && cyc <= m_end[d];
                ew = eb && cyc == m_end[d] && !flush;
                chk((d == 0) ? "busy32" : "busy64", {63'd0, o_busy[d]}, {63'd0, eb});
                chk((d == 0) ? "wop32" : "wop64", {63'd0, o_wop[d]}, {63'd0, ew});
                chk((d == 0) ? "widx32" : "widx64", {59'd0, o_idx[d]}, ew ? {59'd0, m_idx[d]} : 64'd0);
                chk((d == 0) ? "wval32" : "wval64", o_val[d], ew ? m_val[d] : 64'd0);
                if (o_wop[d] === 1'b1) begin
                    last_wcyc[d] = cyc;
                    last_wval[d] = o_val[d];
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic goto_cyc(input longint n);
        while (cyc < n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic scramble();
        rs1    = {$urandom, $urandom};
        rs2    = {$urandom, $urandom};
        rd     = 5'($urandom);
        dec_f3 = 3'($urandom);
    endtask

    task automatic issue(input int d, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] r, output longint ic);
        @(posedge clk); #1;
        op_v[d] = 1'b1;
        dec_op = OPC; dec_f7 = F7MD; dec_f3 = f3;
        rs1 = a; rs2 = b; rd = r;
        ic = cyc;
        @(posedge clk); #1;
        op_v = 2'b00;
        scramble();   // captured operands must not follow the inputs
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((m_act[0] || m_act[1]) && k < 300) begin
            @(negedge clk);
            k++;
        end
        n_chk++;
        if (m_act[0] || m_act[1]) begin
            n_err++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", k);
        end
    endtask

    task automatic run_dir(input int d, input string name, input logic [2:0] f3,
                           input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] exp_val, input longint exp_lat);
        longint ic;
        wait_idle();
        last_wcyc[d] = -1;
        issue(d, f3, a, b, 5'($urandom), ic);
        wait_idle();
        chk({name, "_lat"}, 64'(last_wcyc[d] - ic), 64'(exp_lat));
        chk({name, "_val"}, last_wval[d], exp_val);
    endtask

    function automatic logic [63:0] rand_opnd(input int xlen);
        logic [63:0] v;
        case ($urandom_range(0, 5))
            0: v = 64'd0;
            1: v = 64'hFFFF_FFFF_FFFF_FFFF;
            2: v = 64'd1 << (xlen - 1);
            3: v = 64'($urandom_range(0, 20));
            default: v = {$urandom, $urandom};
        endcase
        return v & xmask(xlen);
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        longint ic;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_busy32", {63'd0, busy32}, 64'd0);
        chk("reset_wop32", {63'd0, wop32}, 64'd0);
        chk("reset_busy64", {63'd0, busy64}, 64'd0);
        chk("reset_wval64", wval64, 64'd0);

        // literal value / latency expectations
        run_dir(0, "mul_7xm3",   3'd0, 64'd7, 64'hFFFFFFFD, 64'hFFFFFFEB, 33);
        run_dir(0, "mulh_m1",    3'd1, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'h00000000, 33);
        run_dir(0, "mulhsu_m1",  3'd2, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 33);
        run_dir(0, "mulhu_m1",   3'd3, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 33);
        run_dir(0, "div_m7_2",   3'd4, 64'hFFFFFFF9, 64'd2, 64'hFFFFFFFD, 33);
        run_dir(0, "rem_m7_2",   3'd6, 64'hFFFFFFF9, 64'd2, 64'hFFFFFFFF, 33);
        run_dir(0, "divu_100_7", 3'd5, 64'd100, 64'd7, 64'd14, 33);
        run_dir(0, "remu_100_7", 3'd7, 64'd100, 64'd7, 64'd2, 33);
        run_dir(0, "divu_5_0",   3'd5, 64'd5, 64'd0, 64'hFFFFFFFF, 1);
        run_dir(0, "rem_5_0",    3'd6, 64'd5, 64'd0, 64'd5, 1);
        run_dir(0, "div_ovf",    3'd4, 64'h80000000, 64'hFFFFFFFF, 64'h80000000, 1);
        run_dir(0, "rem_ovf",    3'd6, 64'h80000000, 64'hFFFFFFFF, 64'd0, 1);
        run_dir(1, "mulhu64",    3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                64'hFFFF_FFFF_FFFF_FFFE, 65);
        run_dir(1, "div64_ovf",  3'd4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                64'h8000_0000_0000_0000, 65);
        run_dir(1, "rem64_neg0", 3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0,
                64'hFFFF_FFFF_FFFF_FFF9, 65);

        // op while busy ignored, flush aborts
        wait_idle();
        last_wcyc[0] = -1;
        issue(0, 3'd0, 64'd3, 64'd5, 5'd9, ic);
        goto_cyc(ic + 5);
        op_v[0] = 1'b1; dec_op = OPC; dec_f7 = F7MD;
        goto_cyc(ic + 6);
        op_v[0] = 1'b0;
        goto_cyc(ic + 10);
        flush = 1'b1;
        goto_cyc(ic + 11);
        flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", {63'd0, busy32}, 64'd0);
        repeat (30) @(negedge clk);
        chk("flush_nowrite", 64'(last_wcyc[0]), 64'hFFFF_FFFF_FFFF_FFFF);

        // flush during the write cycle suppresses it
        wait_idle();
        last_wcyc[0] = -1;
        issue(0, 3'd0, 64'd3, 64'd5, 5'd9, ic);
        goto_cyc(ic + 33);
        flush = 1'b1;
        goto_cyc(ic + 34);
        flush = 1'b0;
        @(negedge clk);
        chk("flush_done_nowrite", 64'(last_wcyc[0]), 64'hFFFF_FFFF_FFFF_FFFF);

        // reset mid-operation
        wait_idle();
        issue(0, 3'd4, 64'd1000, 64'd3, 5'd4, ic);
        goto_cyc(ic + 20);
        rst_n = 1'b0;
        goto_cyc(ic + 21);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", {63'd0, busy32}, 64'd0);
        chk("rst_wop", {63'd0, wop32}, 64'd0);
        chk("rst_widx", {59'd0, widx32}, 64'd0);
        chk("rst_wval", {32'd0, wval32}, 64'd0);
        run_dir(0, "after_rst", 3'd5, 64'd1000, 64'd3, 64'd333, 33);

        // randomized traffic with stray ops and flushes
        for (int i = 0; i < 90; i++) begin
            int d, xl, k;
            d  = (i % 5 == 4) ? 1 : 0;
            xl = (d == 0) ? 32 : 64;
            wait_idle();
            issue(d, 3'($urandom), rand_opnd(xl), rand_opnd(xl), 5'($urandom), ic);
            k = 0;
            while (m_act[d] && k < 300) begin
                if ($urandom_range(0, 59) == 0) flush = 1'b1;
                if ($urandom_range(0, 9) == 0) begin
                    op_v[d] = 1'b1;
                    dec_op  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : OPC;
                    dec_f7  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : F7MD;
                    scramble();
                end
                @(posedge clk); #1;
                flush = 1'b0;
                op_v  = 2'b00;
                k++;
            end
        end
        wait_idle();
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
